// File: rtl/codec_ctrl_arbiter_if.sv
// Bus bundle for codec_ctrl_arbiter: requester ports, init status, sequencer command side
// and statistics. slave = arbiter view, master = requesters/sequencer/environment view.
interface codec_ctrl_arbiter_if #(
   parameter int unsigned NUM_PORTS = 3,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned WDATA_W   = 9,
   parameter int unsigned RDATA_W   = 8
);
   logic                         init_done;
   logic                         init_error;
   logic [NUM_PORTS-1:0]         req_rd;
   logic [NUM_PORTS-1:0]         req_wr;
   logic [NUM_PORTS*ADDR_W-1:0]  req_addr;
   logic [NUM_PORTS*WDATA_W-1:0] req_wdata;
   logic [NUM_PORTS-1:0]         req_ack;
   logic [NUM_PORTS-1:0]         rsp_valid;
   logic [RDATA_W-1:0]           rsp_rdata;
   logic                         rsp_error;
   logic                         arb_busy;
   logic                         ctl_rd_en;
   logic                         ctl_wr_en;
   logic [ADDR_W-1:0]            ctl_reg_addr;
   logic [WDATA_W-1:0]           ctl_data_out;
   logic [RDATA_W-1:0]           ctl_data_in;
   logic                         ctl_data_in_valid;
   logic                         ctl_busy;
   logic                         ctl_missed_ack;
   logic [15:0]                  stat_txn;
   logic [15:0]                  stat_retry;
   logic [15:0]                  stat_error;

   modport slave (
      input  init_done, init_error, req_rd, req_wr, req_addr, req_wdata,
             ctl_data_in, ctl_data_in_valid, ctl_busy, ctl_missed_ack,
      output req_ack, rsp_valid, rsp_rdata, rsp_error, arb_busy,
             ctl_rd_en, ctl_wr_en, ctl_reg_addr, ctl_data_out,
             stat_txn, stat_retry, stat_error
   );

   modport master (
      output init_done, init_error, req_rd, req_wr, req_addr, req_wdata,
             ctl_data_in, ctl_data_in_valid, ctl_busy, ctl_missed_ack,
      input  req_ack, rsp_valid, rsp_rdata, rsp_error, arb_busy,
             ctl_rd_en, ctl_wr_en, ctl_reg_addr, ctl_data_out,
             stat_txn, stat_retry, stat_error
   );
endinterface

// File: rtl/codec_ctrl_arbiter.sv
// Multi-port front end for i2c_seq_sm: init-locked round-robin arbitration, retry on missed
// ACK, start/done timeouts. Define CODEC_ARB_STATS_EN to build the stat_* counters.
module codec_ctrl_arbiter #(
   parameter int unsigned NUM_PORTS     = 3,
   parameter int unsigned ADDR_W        = 8,
   parameter int unsigned WDATA_W       = 9,
   parameter int unsigned RDATA_W       = 8,
   parameter int unsigned MAX_RETRIES   = 3,
   parameter int unsigned RETRY_GAP     = 16,
   parameter int unsigned START_TIMEOUT = 16,
   parameter int unsigned DONE_TIMEOUT  = 65535
) (
   input logic                  clk,
   input logic                  reset,
   codec_ctrl_arbiter_if.slave  bus
);
   localparam int unsigned PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned CNT_MAX_A = (START_TIMEOUT > RETRY_GAP) ? START_TIMEOUT : RETRY_GAP;
   localparam int unsigned CNT_MAX   = (DONE_TIMEOUT > CNT_MAX_A) ? DONE_TIMEOUT : CNT_MAX_A;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'((START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'((DONE_TIMEOUT > 0) ? DONE_TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((RETRY_GAP > 0) ? RETRY_GAP - 1 : 0);
   localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {IDLE, WAIT_START, WAIT_DONE, GAP, RESPOND} state_t;

   state_t               state_q, state_d;
   logic                 fail_d;
   logic                 lock, found;
   logic [NUM_PORTS-1:0] req_any, elig;
   logic [PW-1:0]        pick, cand;
   logic [PW-1:0]        grant_q, last_q;
   logic                 wr_q, issue_q, fresh_q, missed_q, err_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [3:0]           retry_q;
   logic [RDATA_W-1:0]   rdata_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [WDATA_W-1:0]   wdata_q;
   logic                 missed_now;

   // Round-robin search starts one past the last granted port; only port 0 while locked.
   always_comb begin
      lock    = ~(bus.init_done | bus.init_error);
      req_any = bus.req_rd | bus.req_wr;
      elig    = lock ? (req_any & NUM_PORTS'(1)) : req_any;
      found   = 1'b0;
      pick    = '0;
      cand    = '0;
      for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
         cand = PW'((32'(last_q) + off) % NUM_PORTS);
         if (!found && elig[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   assign missed_now = missed_q | bus.ctl_missed_ack;

   always_comb begin
      state_d = state_q;
      fail_d  = 1'b0;
      case (state_q)
         IDLE:       if (found) state_d = WAIT_START;
         WAIT_START: begin
            if (bus.ctl_busy) state_d = WAIT_DONE;
            else if (cnt_q >= START_LAST) begin
               state_d = RESPOND;
               fail_d  = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!bus.ctl_busy) begin
               if (missed_now && (retry_q < RETRY_MAX)) state_d = GAP;
               else begin
                  state_d = RESPOND;
                  fail_d  = missed_now;
               end
            end else if (cnt_q >= DONE_LAST) begin
               state_d = RESPOND;
               fail_d  = 1'b1;
            end
         end
         GAP:        if (cnt_q >= GAP_LAST) state_d = WAIT_START;
         RESPOND:    state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // Sticky missed-ACK is cleared per attempt so a reissue is judged on its own outcome.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_q  <= '0;
         last_q   <= '0;
         wr_q     <= 1'b0;
         issue_q  <= 1'b0;
         fresh_q  <= 1'b0;
         missed_q <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         retry_q  <= '0;
         rdata_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         issue_q <= 1'b0;
         fresh_q <= 1'b0;
         cnt_q   <= (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
         case (state_q)
            IDLE: if (found) begin
               grant_q  <= pick;
               last_q   <= pick;
               wr_q     <= bus.req_wr[pick];
               addr_q   <= bus.req_addr[pick*ADDR_W +: ADDR_W];
               wdata_q  <= bus.req_wdata[pick*WDATA_W +: WDATA_W];
               issue_q  <= 1'b1;
               fresh_q  <= 1'b1;
               missed_q <= 1'b0;
               rdata_q  <= '0;
            end
            WAIT_DONE: begin
               missed_q <= missed_now;
               if (bus.ctl_data_in_valid) rdata_q <= bus.ctl_data_in;
            end
            GAP: if (state_d == WAIT_START) begin
               retry_q  <= retry_q + 1'b1;
               issue_q  <= 1'b1;
               missed_q <= 1'b0;
            end
            RESPOND: begin
               retry_q  <= '0;
               missed_q <= 1'b0;
               err_q    <= 1'b0;
            end
            default: ;
         endcase
         if (state_d == RESPOND && state_q != RESPOND) err_q <= fail_d;
      end
   end

   always_comb begin
      bus.req_ack      = fresh_q ? (NUM_PORTS'(1) << grant_q) : '0;
      bus.ctl_wr_en    = issue_q & wr_q;
      bus.ctl_rd_en    = issue_q & ~wr_q;
      bus.ctl_reg_addr = addr_q;
      bus.ctl_data_out = wdata_q;
      bus.rsp_valid    = (state_q == RESPOND) ? (NUM_PORTS'(1) << grant_q) : '0;
      bus.rsp_rdata    = (state_q == RESPOND && !wr_q) ? rdata_q : '0;
      bus.rsp_error    = (state_q == RESPOND) & err_q;
      bus.arb_busy     = (state_q != IDLE) | lock;
   end

`ifdef CODEC_ARB_STATS_EN
   logic [15:0] stat_txn_q, stat_retry_q, stat_error_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_txn_q   <= '0;
         stat_retry_q <= '0;
         stat_error_q <= '0;
      end else begin
         if (state_q == RESPOND && stat_txn_q != '1) stat_txn_q <= stat_txn_q + 1'b1;
         if (state_q == RESPOND && err_q && stat_error_q != '1) stat_error_q <= stat_error_q + 1'b1;
         if (state_q == GAP && state_d == WAIT_START && stat_retry_q != '1)
            stat_retry_q <= stat_retry_q + 1'b1;
      end
   end

   assign bus.stat_txn   = stat_txn_q;
   assign bus.stat_retry = stat_retry_q;
   assign bus.stat_error = stat_error_q;
`else
   assign bus.stat_txn   = '0;
   assign bus.stat_retry = '0;
   assign bus.stat_error = '0;
`endif
endmodule

// File: doc/codec_ctrl_arbiter.md
Name: codec_ctrl_arbiter

Overview:
Parametrised multi-requester front end for the I2C sequencing state machine (i2c_seq_sm).
- Arbitrates NUM_PORTS codec register read/write requesters onto the single sequencer command interface.
- Port 0 is the init port and has exclusive access until init completes; all ports then share access round-robin.
- Adds automatic retry on missed ACK, start/completion timeouts, and a per-port response/error handshake.

Parameters:
NUM_PORTS, 3, number of requester ports (2..8); port 0 = init port
ADDR_W, 8, codec register address width
WDATA_W, 9, write data width
RDATA_W, 8, read data width
MAX_RETRIES, 3, reissues after a missed ACK before reporting an error (0..15)
RETRY_GAP, 16, idle cycles between a failed attempt and its reissue
START_TIMEOUT, 16, cycles allowed for ctl_busy to rise after issue
DONE_TIMEOUT, 65535, cycles allowed for ctl_busy to stay high

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
init_done  in  1  init sequence finished
init_error  in  1  init sequence failed
req_rd  in  NUM_PORTS  per-port read request, level, held until req_ack
req_wr  in  NUM_PORTS  per-port write request, level, held until req_ack
req_addr  in  NUM_PORTS*ADDR_W  packed addresses, port i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_PORTS*WDATA_W  packed write data
req_ack  out  NUM_PORTS  one-cycle grant pulse
rsp_valid  out  NUM_PORTS  one-cycle completion pulse to the granted port
rsp_rdata  out  RDATA_W  read data, valid with rsp_valid
rsp_error  out  1  transaction failed, valid with rsp_valid
arb_busy  out  1  high whenever state != IDLE or ports 1..N-1 are locked
ctl_rd_en  out  1  one-cycle read command to the sequencer
ctl_wr_en  out  1  one-cycle write command to the sequencer
ctl_reg_addr  out  ADDR_W  latched address
ctl_data_out  out  WDATA_W  latched write data
ctl_data_in  in  RDATA_W  sequencer read data
ctl_data_in_valid  in  1  sequencer read data strobe
ctl_busy  in  1  sequencer busy
ctl_missed_ack  in  1  sequencer missed-ACK indication
stat_txn  out  16  completed transactions (optional feature)
stat_retry  out  16  retries issued (optional feature)
stat_error  out  16  errored transactions (optional feature)

Behaviour:
- Reset: all outputs 0, FSM to IDLE, retry count 0, round-robin pointer 0. A transaction in flight is abandoned and no rsp_valid is generated.
- Lock: lock = ~(init_done | init_error).
  - While locked, only port 0 is eligible.
  - When unlocked, all ports are eligible round-robin, starting from the port after the last granted one.
- Simultaneous req_rd and req_wr on one port: treated as a write.
- FSM states:
  - IDLE: the eligible request sampled at edge k gives req_ack[i]=1, ctl_rd_en or ctl_wr_en=1, and registered addr/data on ctl_* at k+1. Next state: WAIT_START.
  - WAIT_START: ctl_busy=1 goes to WAIT_DONE. Counter reaching START_TIMEOUT goes to RESPOND with error=1 (no retry).
  - WAIT_DONE:
    - ctl_missed_ack sticky-latched.
    - ctl_data_in captured on ctl_data_in_valid.
    - ctl_busy falls: missed_ack set and retries<MAX_RETRIES goes to GAP; missed_ack set and retries exhausted goes to RESPOND with error=1; otherwise goes to RESPOND with error=0.
    - DONE_TIMEOUT expiry goes to RESPOND with error=1.
  - GAP: waits RETRY_GAP cycles, increments the retry count, reissues the same command (one-cycle ctl_*_en, no new req_ack). Next state: WAIT_START.
  - RESPOND: rsp_valid[granted]=1 for one cycle. rsp_rdata is the captured data for reads, 0 for writes. Clears sticky flags and retry count. Next state: IDLE, with the next grant possible in the following cycle.
- Minimum latency, request to rsp_valid: 1 (grant) + sequencer time + 1.
- Lock asserting mid-transaction: the transaction completes normally; the new lock applies at the next IDLE arbitration.
- A requester deasserting before req_ack is allowed; the request is simply not granted.
- Only the granted port ever sees rsp_valid.

Optional Feature:
CODEC_ARB_STATS_EN:
- Defined:
  - stat_txn increments on each rsp_valid.
  - stat_retry increments on each reissue.
  - stat_error increments on each rsp_valid with rsp_error.
  - All 16-bit, saturating at 16'hFFFF; cleared by reset.
- Undefined: stat_* tied to 0 and no counter logic is instantiated.

Test Plan:
- Init lock: init_done=0; port 0 writes addr 8'h0F with data 9'h000 while port 1 requests. Required: only port 0 is granted. After init_done=1, port 1 is granted on the next IDLE.
- Round-robin: unlocked, ports 0, 1, 2 request continuously. Required: grant order 0,1,2,0,1,2; each port gets rsp_valid once per rotation.
- Read: port 1 reads addr 8'h07; model returns 8'hA5 with valid. Required: rsp_valid[1]=1, rsp_rdata=8'hA5, rsp_error=0.
- Retry: model asserts missed_ack on the first 2 attempts of a write to 8'h04. Required: 3 ctl_wr_en pulses, each reissue spaced ≥16 cycles from the end of the failed attempt, rsp_error=0, stat_retry=2.
- Retry exhaustion and start timeout:
  - missed_ack on every attempt: required 4 attempts total, then rsp_error=1.
  - Model never raises busy: required rsp_error=1 at 16 cycles after issue, no retry.
- Reset mid-transaction: reset asserted in WAIT_DONE. Required: no rsp_valid; all outputs 0 the cycle after reset; FSM returns to IDLE.
